comb_sweep_checker: RTL and testbench
=====================================

# comb_sweep_checker

Self-checking exhaustive stimulus engine for small combinational blocks, for on-board FPGA use. It steps an N-input vector through all 2^N codes, holding each for a fixed number of clocks. It samples the device-under-test output at the end of each hold, compares it against a parameter truth table, and reports the error count and the first failing vector. It sits between the board start button/LEDs and any combinational lab block, and replaces manual delay-based stimulus.

## Interface
- N_IN, 3: number of DUT inputs; legal 1..8.
- HOLD_CYCLES, 10: clocks each vector is held; legal ≥1.
- TRUTH, 8'hE8: expected-output table, width 2^N_IN. Bit i is the expected DUT output for input code i. The default is the 3-input majority function.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- dut_y  in  1  DUT output; combinational function of vec_out.
- vec_out  out  N_IN  stimulus to the DUT. Bit N_IN-1 is the first (MSB) input, e.g. A.
- busy  out  1  high while a sweep runs.
- done  out  1  high from sweep end until the next accepted start or reset.
- pass  out  1  valid when done=1; high iff err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors, range 0..2^N_IN.
- first_err_vec  out  N_IN  code of the first mismatch; valid when first_err_valid=1.
- first_err_valid  out  1  at least one mismatch has been recorded this sweep.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. All outputs are 0: vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid.
- IDLE or DONE, start=1 → RUN. On the same edge:
  - vec_out=0, hold counter=0, busy=1, done=0, pass=0.
  - err_count=0, first_err_valid=0, first_err_vec=0.
- RUN, on each edge:
  - If hold counter < HOLD_CYCLES-1: increment the hold counter; nothing else changes.
  - If hold counter == HOLD_CYCLES-1, this is the sample edge. Compare dut_y with TRUTH[vec_out].
  - On mismatch: err_count+1. If first_err_valid=0, latch first_err_vec=vec_out and set first_err_valid=1.
  - At the sample edge, if vec_out < 2^N_IN-1: vec_out+1 and hold counter=0.
  - At the sample edge, if vec_out == 2^N_IN-1: go to DONE with busy=0, done=1, vec_out=0. pass is set from the final count, including this cycle's compare.
- start while in RUN is ignored.
- DONE holds all results until start or rst.
- Arithmetic rules:
  - err_count cannot overflow, because its width covers 2^N_IN.
  - The vec_out increment never wraps inside RUN; the last-code check precedes the increment.
- rst has priority over start and over every state.

## Timing
- An accepted start makes busy=1 on the next edge.
- busy stays high for exactly 2^N_IN × HOLD_CYCLES cycles. With defaults that is 80 cycles.
- Each code k is driven on vec_out for exactly HOLD_CYCLES cycles. dut_y is sampled on the last of those cycles, giving the DUT HOLD_CYCLES-1 settle clocks.
- err_count and first_err_* update on the sample edge. They are visible the cycle after.
- done, pass and busy=0 all assert on the same edge.
- A start in the same cycle as the DONE transition is ignored (state is still RUN). A start one cycle later is accepted.
- With HOLD_CYCLES=1, every edge in RUN is a sample edge.

## Configuration
- SWEEP_STOP_ON_ERR_EN defined:
  - The first mismatch ends the sweep at its sample edge: RUN → DONE, busy=0, done=1, pass=0, err_count=1.
  - vec_out returns to 0 and first_err_vec holds the failing code.
  - Sweep length is (first_err_vec+1) × HOLD_CYCLES cycles.
- Not defined: the sweep always covers all 2^N_IN codes and counts every mismatch.

## Test plan
- Defaults, DUT = majority(A,B,C), start pulse → busy for 80 cycles. vec_out steps 0..7 every 10 cycles. End state: done=1, pass=1, err_count=0, first_err_valid=0.
- Defaults, DUT output inverted only for code 5 → err_count=1, first_err_vec=5, first_err_valid=1, pass=0.
- Defaults, DUT = constant 0 → err_count=4 (codes 3, 5, 6, 7), first_err_vec=3, pass=0.
- Pulse start at cycle 20 of a running sweep → ignored; done still rises exactly 80 cycles after the original start. Then rst at cycle 30 of a new sweep → next cycle all outputs 0, state IDLE.
- N_IN=2, HOLD_CYCLES=1, TRUTH=4'b0110, DUT = XOR → busy for 4 cycles, pass=1. Second start from DONE clears err_count and done on the accepting edge.
- SWEEP_STOP_ON_ERR_EN, defaults, DUT wrong only at codes 2 and 6 → done after 30 cycles, err_count=1, first_err_vec=2, pass=0.

Source files
------------

// File: rtl/comb_sweep_checker_if.sv
// Stimulus/result bundle between the sweep checker and its driver.
// master: start button side; slave: the checker itself.
interface comb_sweep_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            dut_y;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_valid;

  modport master (
    output start, dut_y,
    input  vec_out, busy, done, pass,
    input  err_count, first_err_vec,
    input  first_err_valid
  );

  modport slave (
    input  start, dut_y,
    output vec_out, busy, done, pass,
    output err_count, first_err_vec,
    output first_err_valid
  );
endinterface

// File: rtl/comb_sweep_checker.sv
// Exhaustive sweep of a small combinational DUT against a truth table.
// Optional macro SWEEP_STOP_ON_ERR_EN: end the sweep on first mismatch.
module comb_sweep_checker #(
  parameter int                    N_IN        = 3,
  parameter int                    HOLD_CYCLES = 10,
  parameter logic [(1<<N_IN)-1:0]  TRUTH       = 8'hE8
) (
  input logic                 clk,
  input logic                 rst,
  comb_sweep_checker_if.slave sif
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VMAX = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fev_q, fev_d;
  logic            fevv_q, fevv_d;

  logic sample;
  logic mism;
  logic last;
  logic finish;

  assign sample = (state_q == RUN) && (hold_q == HMAX);
  assign mism   = sample && (sif.dut_y != TRUTH[vec_q]);
  assign last   = (vec_q == VMAX);
`ifdef SWEEP_STOP_ON_ERR_EN
  assign finish = sample && (last || mism);
`else
  assign finish = sample && last;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fev_q   <= '0;
      fevv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fevv_q  <= fevv_d;
    end
  end

  // Next state: start only counts outside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sif.start) state_d = RUN;
      RUN:     if (finish)    state_d = DONE;
      DONE:    if (sif.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Hold counter, stimulus code and error bookkeeping
  always_comb begin
    hold_d = hold_q;
    vec_d  = vec_q;
    err_d  = err_q;
    fev_d  = fev_q;
    fevv_d = fevv_q;
    if (state_q != RUN) begin
      if (sif.start) begin
        hold_d = '0;
        vec_d  = '0;
        err_d  = '0;
        fev_d  = '0;
        fevv_d = 1'b0;
      end
    end else if (!sample) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = '0;
      vec_d  = finish ? '0 : vec_q + N_IN'(1);
      if (mism) begin
        err_d = err_q + (N_IN+1)'(1);
        if (!fevv_q) begin
          fev_d  = vec_q;
          fevv_d = 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    sif.vec_out         = vec_q;
    sif.busy            = (state_q == RUN);
    sif.done            = (state_q == DONE);
    sif.pass            = (state_q == DONE) && (err_q == '0);
    sif.err_count       = err_q;
    sif.first_err_vec   = fev_q;
    sif.first_err_valid = fevv_q;
  end

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Bench for comb_sweep_checker: default 3-input majority instance and a
// 2-input XOR instance with single-cycle hold.
module tb_comb_sweep_checker;

  typedef struct {
    int inst;
    int mode;
    int err;
    int first;
    int fv;
    int pass;
    int len;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   mode0 = 0;
  int   mode1 = 0;
  int   sel = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  comb_sweep_checker_if #(.N_IN(3)) if0 ();
  comb_sweep_checker_if #(.N_IN(2)) if1 ();

  comb_sweep_checker u0 (
    .clk (clk),
    .rst (rst),
    .sif (if0.slave)
  );

  comb_sweep_checker #(
    .N_IN        (2),
    .HOLD_CYCLES (1),
    .TRUTH       (4'b0110)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .sif (if1.slave)
  );

  function automatic logic f0(input int m, input logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return maj ^ (v == 3'd5);
      2:       return 1'b0;
      3:       return maj ^ ((v == 3'd2) || (v == 3'd6));
      default: return maj;
    endcase
  endfunction

  function automatic logic f1(input int m, input logic [1:0] v);
    return (v[1] ^ v[0]) ^ ((m == 1) && (v == 2'd3));
  endfunction

  assign if0.dut_y = f0(mode0, if0.vec_out);
  assign if1.dut_y = f1(mode1, if1.vec_out);

  int c_busy, c_done, c_pass, c_vec, c_err, c_fev, c_fevv;
  always_comb begin
    c_busy = sel ? int'(if1.busy)            : int'(if0.busy);
    c_done = sel ? int'(if1.done)            : int'(if0.done);
    c_pass = sel ? int'(if1.pass)            : int'(if0.pass);
    c_vec  = sel ? int'(if1.vec_out)         : int'(if0.vec_out);
    c_err  = sel ? int'(if1.err_count)       : int'(if0.err_count);
    c_fev  = sel ? int'(if1.first_err_vec)   : int'(if0.first_err_vec);
    c_fevv = sel ? int'(if1.first_err_valid) : int'(if0.first_err_valid);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic s);
    if (sel == 1) if1.start = s;
    else          if0.start = s;
  endtask

  task automatic run(input vec_t v, input int inject_at);
    int   j;
    int   bad;
    int   hold;
    vec_t e;
    sel  = v.inst;
    hold = (v.inst == 1) ? 1 : 10;
    if (v.inst == 1) mode1 = v.mode;
    else             mode0 = v.mode;
    @(negedge clk);
    set_start(1'b1);
    exp_q.push_back(v);
    @(negedge clk);
    set_start(1'b0);
    chk("acc_busy", c_busy, 1);
    chk("acc_done", c_done, 0);
    chk("acc_pass", c_pass, 0);
    chk("acc_err",  c_err,  0);
    chk("acc_fevv", c_fevv, 0);
    j   = 0;
    bad = 0;
    while (c_busy == 1 && j < 200) begin
      if (c_vec != j / hold) bad++;
      set_start(j == inject_at);
      @(negedge clk);
      j++;
    end
    set_start(1'b0);
    chk("vec_seq_bad", bad, 0);
    chk("sweep_len", j, v.len);
    e = exp_q.pop_front();
    chk("end_done", c_done, 1);
    chk("end_busy", c_busy, 0);
    chk("end_vec",  c_vec,  0);
    chk("end_pass", c_pass, e.pass);
    chk("end_err",  c_err,  e.err);
    chk("end_fev",  c_fev,  e.first);
    chk("end_fevv", c_fevv, e.fv);
  endtask

  vec_t tbl[6];

  initial begin
`ifdef SWEEP_STOP_ON_ERR_EN
    tbl[0] = '{0, 0, 0, 0, 0, 1, 80};
    tbl[1] = '{0, 1, 1, 5, 1, 0, 60};
    tbl[2] = '{0, 2, 1, 3, 1, 0, 40};
    tbl[3] = '{0, 3, 1, 2, 1, 0, 30};
    tbl[4] = '{1, 1, 1, 3, 1, 0, 4};
    tbl[5] = '{1, 0, 0, 0, 0, 1, 4};
`else
    tbl[0] = '{0, 0, 0, 0, 0, 1, 80};
    tbl[1] = '{0, 1, 1, 5, 1, 0, 80};
    tbl[2] = '{0, 2, 4, 3, 1, 0, 80};
    tbl[3] = '{0, 3, 2, 2, 1, 0, 80};
    tbl[4] = '{1, 1, 1, 3, 1, 0, 4};
    tbl[5] = '{1, 0, 0, 0, 0, 1, 4};
`endif
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst0_vec",  int'(if0.vec_out), 0);
    chk("rst0_busy", int'(if0.busy), 0);
    chk("rst0_done", int'(if0.done), 0);
    chk("rst0_pass", int'(if0.pass), 0);
    chk("rst0_err",  int'(if0.err_count), 0);
    chk("rst0_fevv", int'(if0.first_err_valid), 0);
    chk("rst1_busy", int'(if1.busy), 0);
    chk("rst1_done", int'(if1.done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(tbl[i], -1);

    // start mid-sweep is ignored
    run(tbl[0], 20);
    // start on the DONE edge is ignored
    run(tbl[2], 79);
    @(negedge clk);
    chk("late_done", c_done, 1);
    chk("late_busy", c_busy, 0);
    chk("late_err",  c_err, tbl[2].err);

    // reset mid-sweep
    sel   = 0;
    mode0 = 2;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy", c_busy, 1);
    chk("mid_vec",  c_vec, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_vec",  c_vec,  0);
    chk("mrst_busy", c_busy, 0);
    chk("mrst_done", c_done, 0);
    chk("mrst_pass", c_pass, 0);
    chk("mrst_err",  c_err,  0);
    chk("mrst_fev",  c_fev,  0);
    chk("mrst_fevv", c_fevv, 0);
    @(negedge clk);
    chk("idle_busy", c_busy, 0);
    chk("idle_done", c_done, 0);

    // sweep still works after reset
    run(tbl[1], -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
